spectro_ram_arbiter: RTL and testbench
======================================

# spectro_ram_arbiter

Arbitrates the banked spectrogram display RAM between the STFT write path (bin magnitudes, bank/address from the FFT-to-RAM mapper) and the video read path. Reads are real-time and always win. A write that collides with a read on the same bank is held in a small write FIFO and retired on the next cycle its bank is free. Sits between the STFT-to-RAM stage / display scanner and the per-bank block RAMs.

## Interface
- ADDRESS_WIDTH, 12, word address width within one bank
- NO_BANKS, 2, number of RAM banks; bank selects are one-hot
- DATA_WIDTH, 4, pixel word width
- FIFO_DEPTH, 8, write FIFO entries, power of two, ≥2
- clk  in  1  pixel/system clock
- reset  in  1  synchronous, active-high
- wr_valid  in  1  write request, single-cycle, no backpressure
- wr_bank  in  NO_BANKS  one-hot target bank
- wr_addr  in  ADDRESS_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- rd_req  in  1  read request, single-cycle
- rd_bank  in  NO_BANKS  one-hot read bank
- rd_addr  in  ADDRESS_WIDTH  read address
- rd_valid  out  1  rd_data valid strobe
- rd_data  out  DATA_WIDTH  read data
- ram_en  out  NO_BANKS  per-bank enable
- ram_we  out  NO_BANKS  per-bank write enable
- ram_addr  out  NO_BANKS*ADDRESS_WIDTH  per-bank address, bank i at [i*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- ram_wdata  out  DATA_WIDTH  shared write data
- ram_rdata  in  NO_BANKS*DATA_WIDTH  per-bank read data, 1-cycle synchronous RAM
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries
- overflow  out  1  sticky: a write was dropped

## Operation
- Every accepted write (wr_valid with non-zero wr_bank) is pushed into the FIFO. wr_bank==0 is discarded silently.
- Each cycle, the read is issued first: rd_req with non-zero rd_bank drives ram_en/addr for that bank, ram_we=0. rd_req with rd_bank==0 is ignored, and no rd_valid follows.
- FIFO head is popped and issued (ram_en=ram_we=1 on head bank, ram_wdata=head data) when the FIFO is non-empty and head bank ≠ issued read bank. Otherwise it stalls. At most one write per cycle, in strict FIFO order (no reordering past a stalled head).
- Push while full without a same-cycle pop: new write dropped, overflow←1, cleared only by reset. Push and pop in the same cycle while full: accepted, no overflow.
- Read bank select is registered alongside the RAM access. rd_data is the registered mux of ram_rdata by that bank.
- Multi-hot rd_bank/wr_bank: undefined, not checked.

## Timing
- Reset values: rd_valid=0, rd_data=0, ram_en=0, ram_we=0, fifo_full=0, overflow=0, FIFO empty. Reset mid-operation flushes FIFO contents and cancels in-flight read valids.
- ram_en/ram_we/ram_addr/ram_wdata are combinational from current-cycle requests and FIFO head.
- Read latency: rd_req at cycle N → RAM sampled N → rd_valid=1 and rd_data at N+2. Back-to-back reads fully pipelined.
- Write latency (default): push at N → earliest RAM write at N+1. Each conflict cycle adds 1.
- fifo_full and overflow update on the clock edge after the causing push.

## Configuration
- SPECTRO_ARB_WR_BYPASS_EN defined: when FIFO is empty and wr_bank ≠ issued read bank, the incoming write goes to RAM in the same cycle (latency 0) and is not pushed.
- Undefined: all writes go through the FIFO (latency ≥1).

## Test plan
- Reset, then rd_req bank=01 addr=0x005 with RAM preloaded 0xA → rd_valid and rd_data=0xA exactly 2 cycles later, no other ram_we.
- Write bank=10 addr=0x010 data=0x7, no reads → ram_we[1] at N+1 (N+0 with bypass), FIFO empty after.
- Write bank=01 while rd_req bank=01 continuously for 5 cycles → write stalls 5 cycles, issues on first idle cycle, read data unaffected.
- Hold reads on bank 01, push 9 writes to bank 01 (FIFO_DEPTH=8) → fifo_full after 8th, 9th dropped, overflow=1 and stays 1 until reset.
- Writes alternating banks 01/10 with reads on 01 → bank-10 write behind stalled bank-01 head also waits (order preserved). Final RAM contents match issue order.
- Assert reset with 3 queued writes and a read in flight → no rd_valid, no ram_we afterwards, fifo_full=0, overflow=0.

Source files
------------

// File: rtl/spectro_ram_arbiter.sv
// rtl/spectro_ram_arbiter.sv - banked display RAM arbiter: reads win, colliding writes queue in a FIFO
// Optional same-cycle write bypass when FIFO is empty: define SPECTRO_ARB_WR_BYPASS_EN.
module spectro_ram_arbiter #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int NO_BANKS      = 2,
  parameter int DATA_WIDTH    = 4,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_valid,
  input  logic [NO_BANKS-1:0]               wr_bank,
  input  logic [ADDRESS_WIDTH-1:0]          wr_addr,
  input  logic [DATA_WIDTH-1:0]             wr_data,
  input  logic                              rd_req,
  input  logic [NO_BANKS-1:0]               rd_bank,
  input  logic [ADDRESS_WIDTH-1:0]          rd_addr,
  output logic                              rd_valid,
  output logic [DATA_WIDTH-1:0]             rd_data,
  output logic [NO_BANKS-1:0]               ram_en,
  output logic [NO_BANKS-1:0]               ram_we,
  output logic [NO_BANKS*ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]             ram_wdata,
  input  logic [NO_BANKS*DATA_WIDTH-1:0]    ram_rdata,
  output logic                              fifo_full,
  output logic                              overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [NO_BANKS-1:0]      fifo_bank [FIFO_DEPTH];
  logic [ADDRESS_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [PTR_W:0]           count, count_nxt;

  logic                     rd_go, wr_go, fifo_empty, full_now;
  logic                     pop, push, push_req, drop, bypass;
  logic [NO_BANKS-1:0]      rd_sel, wr_sel;
  logic [ADDRESS_WIDTH-1:0] wr_src_addr;
  logic [DATA_WIDTH-1:0]    wr_src_data;

  logic                     rd_pend_q;
  logic [NO_BANKS-1:0]      rd_bank_q;
  logic [DATA_WIDTH-1:0]    rd_mux;

  always_comb begin
    rd_go      = rd_req && (rd_bank != '0);
    rd_sel     = rd_go ? rd_bank : '0;
    wr_go      = wr_valid && (wr_bank != '0);
    fifo_empty = (count == '0);
    full_now   = (count == DEPTH_CNT);
    // Head stalls on a bank clash; younger entries never overtake it.
    pop        = !fifo_empty && ((fifo_bank[rd_ptr] & rd_sel) == '0);
`ifdef SPECTRO_ARB_WR_BYPASS_EN
    bypass     = wr_go && fifo_empty && ((wr_bank & rd_sel) == '0);
`else
    bypass     = 1'b0;
`endif
    push_req   = wr_go && !bypass;
    push       = push_req && (!full_now || pop);
    drop       = push_req && full_now && !pop;

    wr_sel      = '0;
    wr_src_addr = '0;
    wr_src_data = '0;
    if (pop) begin
      wr_sel      = fifo_bank[rd_ptr];
      wr_src_addr = fifo_addr[rd_ptr];
      wr_src_data = fifo_data[rd_ptr];
    end else if (bypass) begin
      wr_sel      = wr_bank;
      wr_src_addr = wr_addr;
      wr_src_data = wr_data;
    end

    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CNT_ONE;
    else if (pop && !push)
      count_nxt = count - CNT_ONE;
  end

  always_comb begin
    ram_en    = rd_sel | wr_sel;
    ram_we    = wr_sel;
    ram_wdata = wr_src_data;
    ram_addr  = '0;
    for (int i = 0; i < NO_BANKS; i++) begin
      if (rd_sel[i])
        ram_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = rd_addr;
      else if (wr_sel[i])
        ram_addr[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] = wr_src_addr;
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NO_BANKS; i++)
      if (rd_bank_q[i])
        rd_mux = ram_rdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_bank[wr_ptr] <= wr_bank;
      fifo_addr[wr_ptr] <= wr_addr;
      fifo_data[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_full <= 1'b0;
      overflow  <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_bank_q <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count     <= count_nxt;
      fifo_full <= (count_nxt == DEPTH_CNT);
      if (drop)
        overflow <= 1'b1;
      // RAM output appears the cycle after the access; register it once more.
      rd_pend_q <= rd_go;
      rd_bank_q <= rd_sel;
      rd_valid  <= rd_pend_q;
      if (rd_pend_q)
        rd_data <= rd_mux;
    end
  end

endmodule

// File: tb/tb_spectro_ram_arbiter.sv
// tb/tb_spectro_ram_arbiter.sv - directed vector bench for spectro_ram_arbiter with a 2-bank RAM model
module tb_spectro_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [1:0]  wr_bank;
  logic [11:0] wr_addr;
  logic [3:0]  wr_data;
  logic        rd_req;
  logic [1:0]  rd_bank;
  logic [11:0] rd_addr;
  logic        rd_valid;
  logic [3:0]  rd_data;
  logic [1:0]  ram_en, ram_we;
  logic [23:0] ram_addr;
  logic [3:0]  ram_wdata;
  logic [7:0]  ram_rdata = '0;
  logic        fifo_full, overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spectro_ram_arbiter dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .fifo_full(fifo_full), .overflow(overflow)
  );

  typedef struct {
    int          bank;
    logic [11:0] addr;
    logic [3:0]  data;
  } wr_rec_t;

  wr_rec_t     wr_log[$];
  logic [3:0]  mem [0:1][0:4095];
  logic        load_en = 1'b0;
  int          load_b;
  logic [11:0] load_a;
  logic [3:0]  load_d;

  // Synchronous RAM model; records every write actually issued to a bank.
  always @(posedge clk) begin
    if (load_en)
      mem[load_b][load_a] <= load_d;
    for (int i = 0; i < 2; i++) begin
      if (ram_en[i]) begin
        if (ram_we[i]) begin
          mem[i][ram_addr[i*12 +: 12]] <= ram_wdata;
          wr_log.push_back('{i, ram_addr[i*12 +: 12], ram_wdata});
        end else begin
          ram_rdata[i*4 +: 4] <= mem[i][ram_addr[i*12 +: 12]];
        end
      end
    end
  end

  typedef struct {
    logic        rq;
    logic [1:0]  rb;
    logic [11:0] ra;
    logic        wv;
    logic [1:0]  wb;
    logic [11:0] wa;
    logic [3:0]  wd;
    logic [1:0]  en;
    logic [1:0]  we;
    logic [11:0] a0;
    logic [11:0] a1;
    logic [3:0]  wdat;
    logic        rv;
    logic [3:0]  rdat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rq, input logic [1:0] rb, input logic [11:0] ra,
                       input logic wv, input logic [1:0] wb, input logic [11:0] wa,
                       input logic [3:0] wd);
    rd_req = rq; rd_bank = rb; rd_addr = ra;
    wr_valid = wv; wr_bank = wb; wr_addr = wa; wr_data = wd;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, 12'h000, 1'b0, 2'b00, 12'h000, 4'h0);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  int start;

  initial begin
    // Stimulus/expectation table, one row per cycle.
    vecs[0]  = '{0, 2'b00, 12'h000, 0, 2'b00, 12'h000, 4'h0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 0, 4'h0};
    vecs[1]  = '{1, 2'b01, 12'h005, 0, 2'b00, 12'h000, 4'h0, 2'b01, 2'b00, 12'h005, 12'h000, 4'h0, 0, 4'h0};
    vecs[2]  = '{0, 2'b00, 12'h000, 0, 2'b00, 12'h000, 4'h0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 0, 4'h0};
    vecs[3]  = '{0, 2'b00, 12'h000, 0, 2'b00, 12'h000, 4'h0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 1, 4'hA};
`ifdef SPECTRO_ARB_WR_BYPASS_EN
    vecs[4]  = '{0, 2'b00, 12'h000, 1, 2'b10, 12'h010, 4'h7, 2'b10, 2'b10, 12'h000, 12'h010, 4'h7, 0, 4'h0};
    vecs[5]  = '{0, 2'b00, 12'h000, 0, 2'b00, 12'h000, 4'h0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 0, 4'h0};
`else
    vecs[4]  = '{0, 2'b00, 12'h000, 1, 2'b10, 12'h010, 4'h7, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 0, 4'h0};
    vecs[5]  = '{0, 2'b00, 12'h000, 0, 2'b00, 12'h000, 4'h0, 2'b10, 2'b10, 12'h000, 12'h010, 4'h7, 0, 4'h0};
`endif
    vecs[6]  = '{1, 2'b10, 12'h010, 0, 2'b00, 12'h000, 4'h0, 2'b10, 2'b00, 12'h000, 12'h010, 4'h0, 0, 4'h0};
    vecs[7]  = '{1, 2'b01, 12'h005, 0, 2'b00, 12'h000, 4'h0, 2'b01, 2'b00, 12'h005, 12'h000, 4'h0, 0, 4'h0};
    vecs[8]  = '{1, 2'b01, 12'h006, 0, 2'b00, 12'h000, 4'h0, 2'b01, 2'b00, 12'h006, 12'h000, 4'h0, 1, 4'h7};
    vecs[9]  = '{0, 2'b00, 12'h000, 0, 2'b00, 12'h000, 4'h0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 1, 4'hA};
    vecs[10] = '{1, 2'b00, 12'h005, 0, 2'b00, 12'h000, 4'h0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 1, 4'h0};
    vecs[11] = '{0, 2'b00, 12'h000, 0, 2'b00, 12'h000, 4'h0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 0, 4'h0};
    vecs[12] = '{0, 2'b00, 12'h000, 0, 2'b00, 12'h000, 4'h0, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 0, 4'h0};

    reset = 1'b1;
    idle();
    load_en = 1'b1; load_b = 0; load_a = 12'h005; load_d = 4'hA;
    nxt();
    load_a = 12'h006; load_d = 4'h0;
    nxt();
    load_en = 1'b0;
    @(negedge clk);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    chk("reset_ram_en", 32'(ram_en), 32'h0);
    chk("reset_ram_we", 32'(ram_we), 32'h0);
    chk("reset_fifo_full", 32'(fifo_full), 32'h0);
    chk("reset_overflow", 32'(overflow), 32'h0);
    nxt();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].rq, vecs[i].rb, vecs[i].ra, vecs[i].wv, vecs[i].wb, vecs[i].wa, vecs[i].wd);
      @(negedge clk);
      chk($sformatf("vec%0d_ram_en", i), 32'(ram_en), 32'(vecs[i].en));
      chk($sformatf("vec%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].we));
      if (vecs[i].en[0]) chk($sformatf("vec%0d_addr0", i), 32'(ram_addr[11:0]), 32'(vecs[i].a0));
      if (vecs[i].en[1]) chk($sformatf("vec%0d_addr1", i), 32'(ram_addr[23:12]), 32'(vecs[i].a1));
      if (vecs[i].we != 2'b00) chk($sformatf("vec%0d_wdata", i), 32'(ram_wdata), 32'(vecs[i].wdat));
      chk($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(vecs[i].rv));
      if (vecs[i].rv) chk($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].rdat));
      chk($sformatf("vec%0d_fifo_full", i), 32'(fifo_full), 32'h0);
      nxt();
    end

    // Write to bank 0 collides with five back-to-back reads of bank 0.
    for (int k = 0; k < 8; k++) begin
      if (k < 5) drive(1'b1, 2'b01, 12'h005, k == 0, 2'b01, 12'h030, 4'h5);
      else idle();
      @(negedge clk);
      chk($sformatf("stall%0d_ram_we", k), 32'(ram_we), (k == 5) ? 32'h1 : 32'h0);
      if (k == 5) begin
        chk("stall_issue_addr", 32'(ram_addr[11:0]), 32'h030);
        chk("stall_issue_wdata", 32'(ram_wdata), 32'h5);
      end
      chk($sformatf("stall%0d_rd_valid", k), 32'(rd_valid), (k >= 2 && k <= 6) ? 32'h1 : 32'h0);
      if (k >= 2 && k <= 6) chk($sformatf("stall%0d_rd_data", k), 32'(rd_data), 32'hA);
      nxt();
    end
    drive(1'b1, 2'b01, 12'h030, 1'b0, 2'b00, 12'h000, 4'h0);
    nxt();
    idle();
    nxt();
    @(negedge clk);
    chk("stall_readback_valid", 32'(rd_valid), 32'h1);
    chk("stall_readback_data", 32'(rd_data), 32'h5);
    nxt();

    // Fill the FIFO behind a blocked bank, then overflow it with a ninth write.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 2'b01, 12'h005, i < 9, 2'b01, 12'h040 + 12'(i), 4'(i));
      @(negedge clk);
      chk($sformatf("ovf%0d_ram_we", i), 32'(ram_we), 32'h0);
      if (i == 7) chk("ovf_full_before_8th", 32'(fifo_full), 32'h0);
      if (i == 8) begin
        chk("ovf_full_after_8th", 32'(fifo_full), 32'h1);
        chk("ovf_not_yet", 32'(overflow), 32'h0);
      end
      if (i == 9) chk("ovf_set", 32'(overflow), 32'h1);
      nxt();
    end
    start = wr_log.size();
    idle();
    for (int j = 0; j < 10; j++) nxt();
    @(negedge clk);
    chk("ovf_sticky", 32'(overflow), 32'h1);
    chk("ovf_full_drained", 32'(fifo_full), 32'h0);
    chk("ovf_drain_count", 32'(wr_log.size() - start), 32'h8);
    for (int e = 0; e < 8; e++) begin
      if (start + e < wr_log.size()) begin
        chk($sformatf("ovf_drain%0d_addr", e), 32'(wr_log[start+e].addr), 32'h040 + 32'(e));
        chk($sformatf("ovf_drain%0d_data", e), 32'(wr_log[start+e].data), 32'(e));
      end
    end
    nxt();

    // Reset with three queued writes and a read in flight.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 2'b01, 12'h005, c < 3, 2'b01, 12'h060 + 12'(c), 4'(c + 1));
      if (c == 3) reset = 1'b1;
      nxt();
    end
    reset = 1'b0;
    idle();
    start = wr_log.size();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("rst%0d_rd_valid", c), 32'(rd_valid), 32'h0);
      chk($sformatf("rst%0d_ram_we", c), 32'(ram_we), 32'h0);
      chk($sformatf("rst%0d_fifo_full", c), 32'(fifo_full), 32'h0);
      chk($sformatf("rst%0d_overflow", c), 32'(overflow), 32'h0);
      nxt();
    end
    chk("rst_no_writes", 32'(wr_log.size() - start), 32'h0);

    // Bank-1 writes queued behind a stalled bank-0 head must keep their order.
    for (int c = 0; c < 4; c++) begin
      drive(1'b1, 2'b01, 12'h005, 1'b1, (c % 2 == 0) ? 2'b01 : 2'b10,
            (c % 2 == 0) ? 12'h050 : 12'h051, 4'(c + 1));
      @(negedge clk);
      chk($sformatf("order%0d_ram_we", c), 32'(ram_we), 32'h0);
      nxt();
    end
    start = wr_log.size();
    idle();
    for (int j = 0; j < 6; j++) nxt();
    chk("order_count", 32'(wr_log.size() - start), 32'h4);
    for (int e = 0; e < 4; e++) begin
      if (start + e < wr_log.size()) begin
        chk($sformatf("order%0d_bank", e), 32'(wr_log[start+e].bank), 32'(e % 2));
        chk($sformatf("order%0d_data", e), 32'(wr_log[start+e].data), 32'(e + 1));
      end
    end
    drive(1'b1, 2'b01, 12'h050, 1'b0, 2'b00, 12'h000, 4'h0);
    nxt();
    drive(1'b1, 2'b10, 12'h051, 1'b0, 2'b00, 12'h000, 4'h0);
    nxt();
    idle();
    @(negedge clk);
    chk("order_final_b0_valid", 32'(rd_valid), 32'h1);
    chk("order_final_b0_data", 32'(rd_data), 32'h3);
    nxt();
    @(negedge clk);
    chk("order_final_b1_valid", 32'(rd_valid), 32'h1);
    chk("order_final_b1_data", 32'(rd_data), 32'h4);
    nxt();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
